// File: rtl/run_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module  : run_ctrl                                                         |
// | Brief   : Preloads dat_mem, releases the core, counts run cycles, acks.    |
// |           Optional watchdog enabled by defining RUN_WATCHDOG_EN.           |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module run_ctrl #(
  parameter int AW      = 8,
  parameter int CW      = 16,
  parameter int TIMEOUT = 4095
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic [AW-1:0] ld_len,
  input  logic          ld_valid,
  input  logic [7:0]    ld_data,
  output logic          ld_ready,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wr_data,
  output logic          core_reset,
  input  logic          core_done,
  output logic          busy,
  output logic          ack,
  output logic [CW-1:0] cycles,
  output logic          timed_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  localparam logic [AW-1:0] c_addr_one = AW'(1);
  localparam logic [CW-1:0] c_cyc_one  = CW'(1);
  localparam logic [CW-1:0] c_cyc_max  = '1;
`ifdef RUN_WATCHDOG_EN
  localparam bit c_wd_en = 1'b1;
`else
  localparam bit c_wd_en = 1'b0;
`endif

  state_t        r_state;
  state_t        w_next_state;
  logic [AW-1:0] r_len;
  logic [AW-1:0] r_addr;
  logic [CW-1:0] r_cycles;
  logic          r_timed_out;
  logic          r_core_reset;
  logic          w_transfer;
  logic          w_last_byte;
  logic          w_timeout_hit;

  // Full-width compare so a TIMEOUT beyond the counter range simply never fires.
  always_comb begin
    w_transfer    = (r_state == S_LOAD) && ld_valid;
    w_last_byte   = w_transfer && (r_addr == (r_len - c_addr_one));
    w_timeout_hit = c_wd_en && (32'(r_cycles) == 32'(TIMEOUT));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    ld_ready     = 1'b0;
    busy         = 1'b1;
    ack          = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (req) begin
          w_next_state = (ld_len == '0) ? S_RUN : S_LOAD;
        end
      end
      S_LOAD: begin
        ld_ready = 1'b1;
        if (w_last_byte) begin
          w_next_state = S_RUN;
        end
      end
      S_RUN: begin
        if (core_done || w_timeout_hit) begin
          w_next_state = S_FIN;
        end
      end
      S_FIN: begin
        ack          = 1'b1;
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // core_reset comes from its own flop, loaded alongside the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_len        <= '0;
      r_addr       <= '0;
      r_cycles     <= '0;
      r_timed_out  <= 1'b0;
      r_core_reset <= 1'b1;
    end else begin
      r_core_reset <= (w_next_state != S_RUN);
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_len       <= ld_len;
            r_addr      <= '0;
            r_cycles    <= '0;
            r_timed_out <= 1'b0;
          end
        end
        S_LOAD: begin
          if (w_transfer) begin
            r_addr <= r_addr + c_addr_one;
          end
        end
        S_RUN: begin
          if (!core_done) begin
            if (w_timeout_hit) begin
              r_timed_out <= 1'b1;
            end else if (r_cycles != c_cyc_max) begin
              r_cycles <= r_cycles + c_cyc_one;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign mem_wr_en   = w_transfer;
  assign mem_addr    = r_addr;
  assign mem_wr_data = ld_data;
  assign core_reset  = r_core_reset;
  assign cycles      = r_cycles;
  assign timed_out   = r_timed_out;

endmodule

`default_nettype wire

// File: tb/tb_run_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module  : tb_run_ctrl                                                      |
// | Brief   : Self-checking bench for run_ctrl with a run-length reference.    |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_run_ctrl;

  localparam int AW  = 8;
  localparam int CW  = 16;
  localparam int TO  = 20;
  localparam int SCW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req = 1'b0;
  logic [AW-1:0] ld_len = '0;
  logic          ld_valid = 1'b0;
  logic [7:0]    ld_data = '0;
  logic          core_done = 1'b0;
  logic          ld_ready, mem_wr_en, core_reset, busy, ack, timed_out;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wr_data;
  logic [CW-1:0] cycles;

  logic          s_req = 1'b0;
  logic          s_done = 1'b0;
  logic          s_ld_ready, s_mem_wr_en, s_core_reset, s_busy, s_ack, s_timed_out;
  logic [AW-1:0] s_mem_addr;
  logic [7:0]    s_mem_wr_data;
  logic [SCW-1:0] s_cycles;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  run_ctrl #(.AW(AW), .CW(CW), .TIMEOUT(TO)) u_dut (
    .clk(clk), .reset(reset), .req(req), .ld_len(ld_len), .ld_valid(ld_valid),
    .ld_data(ld_data), .ld_ready(ld_ready), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .core_reset(core_reset), .core_done(core_done),
    .busy(busy), .ack(ack), .cycles(cycles), .timed_out(timed_out)
  );

  run_ctrl #(.AW(AW), .CW(SCW)) u_sat (
    .clk(clk), .reset(reset), .req(s_req), .ld_len('0), .ld_valid(1'b0),
    .ld_data(8'h00), .ld_ready(s_ld_ready), .mem_wr_en(s_mem_wr_en), .mem_addr(s_mem_addr),
    .mem_wr_data(s_mem_wr_data), .core_reset(s_core_reset), .core_done(s_done),
    .busy(s_busy), .ack(s_ack), .cycles(s_cycles), .timed_out(s_timed_out)
  );

  // Reference: a run whose core raises done after n idle RUN cycles.
  function automatic void model_run(input int n_done, input int cw, input bit wd,
                                    output int end_k, output int exp_cyc, output bit exp_to);
    int max_c;
    max_c   = (1 << cw) - 1;
    end_k   = n_done;
    exp_cyc = (n_done < max_c) ? n_done : max_c;
    exp_to  = 1'b0;
    if (wd && n_done > TO) begin
      end_k   = TO;
      exp_cyc = TO;
      exp_to  = 1'b1;
    end
  endfunction

  task automatic do_run(input int len, input int min_gap, input int max_gap,
                        input int n_done, input bit noise);
    int end_k, exp_cyc;
    bit exp_to, wd;
    logic [7:0] d;
`ifdef RUN_WATCHDOG_EN
    wd = 1'b1;
`else
    wd = 1'b0;
`endif
    model_run(n_done, CW, wd, end_k, exp_cyc, exp_to);
    @(negedge clk);
    req = 1'b1; ld_len = AW'(len);
    ld_valid  = noise ? 1'($urandom) : 1'b0;
    core_done = noise ? 1'($urandom) : 1'b0;
    #1 checks++;
    if ({busy, ld_ready, mem_wr_en, core_reset, ack} !== 5'b00010) begin
      errors++; $display("FAIL idle_outputs: got %b expected 00010", {busy, ld_ready, mem_wr_en, core_reset, ack});
    end
    @(negedge clk);
    req = 1'b0; ld_valid = 1'b0; core_done = 1'b0;
    for (int i = 0; i < len; i++) begin
      repeat ($urandom_range(min_gap, max_gap)) begin
        if (noise) begin req = 1'($urandom); core_done = 1'($urandom); end
        #1 checks++;
        if ({ld_ready, mem_wr_en, core_reset, busy} !== 4'b1011) begin
          errors++; $display("FAIL load_stall: got %b expected 1011", {ld_ready, mem_wr_en, core_reset, busy});
        end
        @(negedge clk);
        req = 1'b0; core_done = 1'b0;
      end
      d = 8'($urandom);
      ld_valid = 1'b1; ld_data = d;
      #1 checks++;
      if ({mem_wr_en, mem_addr, mem_wr_data} !== {1'b1, AW'(i), d}) begin
        errors++; $display("FAIL load_write: got en=%b addr=%0d data=%h expected en=1 addr=%0d data=%h",
                           mem_wr_en, mem_addr, mem_wr_data, i, d);
      end
      @(negedge clk);
      ld_valid = 1'b0;
    end
    for (int k = 0; k <= end_k; k++) begin
      core_done = (k == n_done);
      if (noise) req = 1'($urandom);
      #1 checks++;
      if ({core_reset, busy, ack, ld_ready} !== 4'b0100) begin
        errors++; $display("FAIL run_outputs: cycle %0d got %b expected 0100", k, {core_reset, busy, ack, ld_ready});
      end
      @(negedge clk);
    end
    req = 1'b0; core_done = 1'b0;
    #1 checks++;
    if ({ack, busy, core_reset} !== 3'b111) begin
      errors++; $display("FAIL fin_ack: got %b expected 111", {ack, busy, core_reset});
    end
    checks++;
    if (cycles !== CW'(exp_cyc) || timed_out !== exp_to) begin
      errors++; $display("FAIL run_result: got cycles=%0d to=%b expected cycles=%0d to=%b",
                         cycles, timed_out, exp_cyc, exp_to);
    end
    @(negedge clk);
    #1 checks++;
    if ({ack, busy, cycles, timed_out} !== {2'b00, CW'(exp_cyc), exp_to}) begin
      errors++; $display("FAIL idle_after: got ack=%b busy=%b cycles=%0d to=%b expected 0 0 %0d %b",
                         ack, busy, cycles, timed_out, exp_cyc, exp_to);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1 checks++;
    if ({core_reset, ld_ready, mem_wr_en, mem_addr, busy, ack, cycles, timed_out} !==
        {1'b1, 1'b0, 1'b0, AW'(0), 1'b0, 1'b0, CW'(0), 1'b0}) begin
      errors++; $display("FAIL reset_values: got cr=%b rdy=%b we=%b addr=%0d busy=%b ack=%b cyc=%0d to=%b",
                         core_reset, ld_ready, mem_wr_en, mem_addr, busy, ack, cycles, timed_out);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    req = 1'b1; ld_len = '0;
    @(negedge clk);
    for (int k = 0; k <= 3; k++) begin
      core_done = (k == 3);
      #1 checks++;
      if (core_reset !== 1'b0) begin
        errors++; $display("FAIL b2b_run: got core_reset=%b expected 0", core_reset);
      end
      @(negedge clk);
    end
    core_done = 1'b0;
    #1 checks++;
    if ({ack, cycles} !== {1'b1, CW'(3)}) begin
      errors++; $display("FAIL b2b_fin: got ack=%b cycles=%0d expected 1 3", ack, cycles);
    end
    @(negedge clk);
    #1 checks++;
    if ({busy, ack, cycles} !== {2'b00, CW'(3)}) begin
      errors++; $display("FAIL b2b_idle: got busy=%b ack=%b cycles=%0d expected 0 0 3", busy, ack, cycles);
    end
    @(negedge clk);
    #1 checks++;
    if ({busy, core_reset, cycles} !== {2'b10, CW'(0)}) begin
      errors++; $display("FAIL b2b_retrigger: got busy=%b cr=%b cycles=%0d expected 1 0 0", busy, core_reset, cycles);
    end
    req = 1'b0; core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    #1 checks++;
    if ({ack, cycles} !== {1'b1, CW'(0)}) begin
      errors++; $display("FAIL b2b_second_ack: got ack=%b cycles=%0d expected 1 0", ack, cycles);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_load();
    @(negedge clk);
    req = 1'b1; ld_len = AW'(3);
    @(negedge clk);
    req = 1'b0; ld_valid = 1'b1; ld_data = 8'h5A;
    @(negedge clk);
    ld_data = 8'h6B; reset = 1'b1;
    #1 checks++;
    if ({core_reset, ld_ready, mem_wr_en, mem_addr, busy, ack, cycles, timed_out} !==
        {1'b1, 1'b0, 1'b0, AW'(0), 1'b0, 1'b0, CW'(0), 1'b0}) begin
      errors++; $display("FAIL reset_mid_load: got cr=%b rdy=%b we=%b addr=%0d busy=%b ack=%b cyc=%0d to=%b",
                         core_reset, ld_ready, mem_wr_en, mem_addr, busy, ack, cycles, timed_out);
    end
    @(negedge clk);
    reset = 1'b0; ld_valid = 1'b0;
    do_run(2, 0, 1, 3, 1'b0);
  endtask

  task automatic test_saturation();
    @(negedge clk);
    s_req = 1'b1;
    @(negedge clk);
    s_req = 1'b0;
    for (int k = 0; k <= 20; k++) begin
      s_done = (k == 20);
      #1 checks++;
      if (s_cycles !== SCW'((k < 15) ? k : 15)) begin
        errors++; $display("FAIL sat_count: cycle %0d got %0d expected %0d", k, s_cycles, (k < 15) ? k : 15);
      end
      @(negedge clk);
    end
    s_done = 1'b0;
    #1 checks++;
    if ({s_ack, s_cycles, s_timed_out} !== {1'b1, SCW'(15), 1'b0}) begin
      errors++; $display("FAIL sat_final: got ack=%b cycles=%0d to=%b expected 1 15 0", s_ack, s_cycles, s_timed_out);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    do_run(0, 0, 0, 10, 1'b0);       // basic run, no preload
    do_run(3, 2, 2, 5, 1'b0);        // preload with two-cycle gaps
    do_run(3, 0, 3, 8, 1'b1);        // stray req/done/valid ignored
    test_back_to_back();
    test_reset_mid_load();
    do_run(255, 0, 0, 2, 1'b0);      // maximum preload length
    do_run(0, 0, 0, TO, 1'b0);       // done coincides with watchdog limit
    do_run(0, 0, 0, 40, 1'b0);       // watchdog expiry when enabled
    for (int r = 0; r < 8; r++) begin
      do_run($urandom_range(0, 6), 0, 2, $urandom_range(0, 25), 1'b1);
    end
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
